// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice: state encoding,
// default byte width and a constant-evaluable ceil(log2) helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int UART_DATA_WIDTH = 8;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans req starting one past the
// previous winner, wrapping modulo NUM_REQ; the first set bit wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_vld_s;

    // Rotating priority scan over offsets 1..NUM_REQ from the last winner
    always_comb begin
        pick_idx_s = '0;
        pick_vld_s = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int               cand;
            logic [IDX_W-1:0] cand_idx;
            logic             hit;
            cand       = (int'(last) + off) % NUM_REQ;
            cand_idx   = IDX_W'(cand);
            hit        = req[cand_idx] & ~pick_vld_s;
            pick_idx_s = hit ? cand_idx : pick_idx_s;
            pick_vld_s = pick_vld_s | hit;
        end
    end

    // One-hot expansion of the selected index
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner[i] = pick_vld_s && (pick_idx_s == IDX_W'(i));
        end
    end

    assign winner_idx = pick_idx_s;
    assign valid      = pick_vld_s;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ byte sources.
// Optional WAIT-state watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_bus,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic                          err,
    output logic                          tx_wr_en,
    output logic [DATA_WIDTH-1:0]         tx_din,
    input  logic                          tx_done
);

    localparam int IDX_W = clog2(NUM_REQ);

    if ((NUM_REQ < 2) || (NUM_REQ > 16)) begin : g_bad_num_req
        $error("uart_tx_arb: NUM_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arb: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e              state_r;
    logic [IDX_W-1:0]        last_r;
    logic [IDX_W-1:0]        owner_r;
    logic [DATA_WIDTH-1:0]   tx_din_r;
    logic                    tx_wr_en_r;
    logic                    busy_r;
    logic [NUM_REQ-1:0]      done_r;

    logic [NUM_REQ-1:0]      win_oh_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_vld_s;
    logic                    grant_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic [NUM_REQ-1:0]      owner_oh_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last       (last_r),
        .winner     (win_oh_s),
        .winner_idx (win_idx_s),
        .valid      (win_vld_s)
    );

    // Grant is combinational so the requester sees it in the cycle its byte is taken
    always_comb begin
        grant_s = (state_r == IDLE) && win_vld_s && rst;
        if (grant_s) begin
            gnt = win_oh_s;
        end else begin
            gnt = '0;
        end
    end

    // Select the winning requester's byte from the flat bus
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == IDX_W'(i)) begin
                win_data_s = din_bus[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // One-hot decode of the current owner for the completion pulse
    always_comb begin
        owner_oh_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh_s[i] = (owner_r == IDX_W'(i));
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_r;
    logic             err_r;

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Arbiter FSM with owner/last tracking, data capture and optional watchdog
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            last_r     <= IDX_W'(NUM_REQ - 1);
            owner_r    <= '0;
            tx_din_r   <= '0;
            tx_wr_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt_r   <= '0;
            err_r      <= 1'b0;
`endif
        end else begin
            tx_wr_en_r <= 1'b0;
            done_r     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_r      <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r    <= ISSUE;
                        last_r     <= win_idx_s;
                        owner_r    <= win_idx_s;
                        tx_din_r   <= win_data_s;
                        tx_wr_en_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wd_cnt_r <= '0;
`endif
                end
                WAIT: begin
                    // Completion wins over a watchdog expiry in the same cycle
                    if (tx_done) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= owner_oh_s;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        err_r   <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_din   = tx_din_r;
    assign tx_wr_en = tx_wr_en_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NUM_REQ=4, 8-bit bytes).
module tb_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int TO      = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*DW-1:0]  din_bus;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic                   err;
    logic                   tx_wr_en;
    logic [DW-1:0]          tx_din;
    logic                   tx_done;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_arb #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din_bus  (din_bus),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .tx_wr_en (tx_wr_en),
        .tx_din   (tx_din),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input int idx);
        case (idx)
            0:       return 8'h11;
            1:       return 8'h22;
            2:       return 8'hA5;
            3:       return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        rst     = 1'b0;
        req     = 4'b0000;
        tx_done = 1'b0;
        din_bus = {8'h44, 8'hA5, 8'h22, 8'h11};

        // reset state
        nxt();
        nxt();
        #1;
        chk("rst_gnt",   32'(gnt),      32'h0);
        chk("rst_done",  32'(done),     32'h0);
        chk("rst_busy",  32'(busy),     32'h0);
        chk("rst_err",   32'(err),      32'h0);
        chk("rst_wr_en", 32'(tx_wr_en), 32'h0);
        chk("rst_din",   32'(tx_din),   32'h0);
        rst = 1'b1;
        nxt();

        // single request from requester 2
        req = 4'b0100;
        #1;
        chk("single_gnt",  32'(gnt),  32'h4);
        chk("single_busy", 32'(busy), 32'h0);
        chk("single_wr0",  32'(tx_wr_en), 32'h0);
        nxt();
        req = 4'b0000;
        #1;
        chk("single_wr1",  32'(tx_wr_en), 32'h1);
        chk("single_din",  32'(tx_din),   32'hA5);
        chk("single_busy1", 32'(busy),    32'h1);
        chk("single_gnt0", 32'(gnt),      32'h0);
        nxt();
        #1;
        chk("single_wr_off", 32'(tx_wr_en), 32'h0);
        chk("single_busy_w", 32'(busy),     32'h1);
        nxt();
        tx_done = 1'b1;
        #1;
        chk("single_done_early", 32'(done), 32'h0);
        nxt();
        tx_done = 1'b0;
        #1;
        chk("single_done", 32'(done), 32'h4);
        chk("single_idle", 32'(busy), 32'h0);
        nxt();
        #1;
        chk("single_done_pulse", 32'(done), 32'h0);

        // spurious tx_done while idle
        tx_done = 1'b1;
        nxt();
        tx_done = 1'b0;
        #1;
        chk("spur_idle_done", 32'(done),     32'h0);
        chk("spur_idle_busy", 32'(busy),     32'h0);
        chk("spur_idle_wr",   32'(tx_wr_en), 32'h0);

        // spurious tx_done during ISSUE; data held through WAIT
        req = 4'b0001;
        #1;
        chk("spur_iss_gnt", 32'(gnt), 32'h1);
        nxt();
        req     = 4'b0000;
        tx_done = 1'b1;
        #1;
        chk("spur_iss_wr",  32'(tx_wr_en), 32'h1);
        chk("spur_iss_din", 32'(tx_din),   32'h11);
        nxt();
        tx_done = 1'b0;
        #1;
        chk("spur_iss_busy", 32'(busy), 32'h1);
        chk("spur_iss_done", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk("wait_din_hold", 32'(tx_din), 32'h11);
            chk("wait_busy",     32'(busy),   32'h1);
        end
        tx_done = 1'b1;
        nxt();
        tx_done = 1'b0;
        #1;
        chk("spur_iss_done_real", 32'(done),   32'h1);
        chk("din_hold_idle",      32'(tx_din), 32'h11);

        // reset asserted during WAIT
        nxt();
        req = 4'b0010;
        #1;
        chk("rstw_gnt", 32'(gnt), 32'h2);
        nxt();
        req = 4'b0000;
        nxt();
        nxt();
        rst = 1'b0;
        nxt();
        rst = 1'b1;
        #1;
        chk("rstw_busy", 32'(busy),     32'h0);
        chk("rstw_din",  32'(tx_din),   32'h0);
        chk("rstw_done", 32'(done),     32'h0);
        chk("rstw_wr",   32'(tx_wr_en), 32'h0);
        nxt();
        tx_done = 1'b1;
        #1;
        chk("rstw_done_after", 32'(done), 32'h0);
        nxt();
        tx_done = 1'b0;
        #1;
        chk("rstw_stray_done", 32'(done), 32'h0);

        // contention: all four requesting, rotation restarts at 0 after reset
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int exp_w;
            exp_w = k % NUM_REQ;
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1) << exp_w);
            nxt();
            #1;
            chk("rr_wr",  32'(tx_wr_en), 32'h1);
            chk("rr_din", 32'(tx_din),   32'(byte_of(exp_w)));
            nxt();
            nxt();
            tx_done = 1'b1;
            nxt();
            tx_done = 1'b0;
            if (k == 4) begin
                req = 4'b0000;
            end
            #1;
            chk("rr_done", 32'(done), 32'(1) << exp_w);
        end
        #1;
        chk("rr_no_gnt", 32'(gnt), 32'h0);

        // one requester holding req wins consecutive slots
        nxt();
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hold_gnt", 32'(gnt), 32'h4);
            nxt();
            nxt();
            nxt();
            tx_done = 1'b1;
            nxt();
            tx_done = 1'b0;
            if (k == 1) begin
                req = 4'b0000;
            end
            #1;
            chk("hold_done", 32'(done), 32'h4);
        end

`ifdef UART_TX_ARB_TIMEOUT_EN
        // watchdog: tx_done never arrives
        nxt();
        req = 4'b1000;
        #1;
        chk("to_gnt", 32'(gnt), 32'h8);
        nxt();
        req = 4'b0000;
        nxt();
        repeat (15) nxt();
        #1;
        chk("to_err_pre",  32'(err),  32'h0);
        chk("to_busy_pre", 32'(busy), 32'h1);
        nxt();
        #1;
        chk("to_err",  32'(err),  32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_done", 32'(done), 32'h0);
        req = 4'b0001;
        #1;
        chk("to_next_gnt", 32'(gnt), 32'h1);
        nxt();
        req = 4'b0000;
        #1;
        chk("to_err_pulse", 32'(err),      32'h0);
        chk("to_next_wr",   32'(tx_wr_en), 32'h1);
        nxt();
        tx_done = 1'b1;
        nxt();
        tx_done = 1'b0;
        #1;
        chk("to_next_done", 32'(done), 32'h1);
`else
        // no watchdog: WAIT holds indefinitely
        nxt();
        req = 4'b1000;
        #1;
        chk("nto_gnt", 32'(gnt), 32'h8);
        nxt();
        req = 4'b0000;
        for (int i = 0; i < 10000; i++) begin
            nxt();
            if ((i % 1000) == 999) begin
                #1;
                chk("nto_busy", 32'(busy), 32'h1);
                chk("nto_err",  32'(err),  32'h0);
            end
        end
        tx_done = 1'b1;
        nxt();
        tx_done = 1'b0;
        #1;
        chk("nto_done", 32'(done), 32'h8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer sharing one `uart_tx` transmitter among `NUM_REQ` byte sources. It accepts one byte per grant, issues a single-cycle write strobe with the data held stable, and waits for the transmitter's `tx_done` before it arbitrates again. It sits between the client logic (command responders, debug loggers) and the single `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2–16.
- `DATA_WIDTH`, 8: byte width; must match `uart_tx`.
- `TIMEOUT_CYCLES`, 1_200_000: watchdog limit in clk cycles (only used with the macro).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  NUM_REQ  per-requester byte-pending level.
- `din_bus`  in  NUM_REQ*DATA_WIDTH  requester i's byte is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse; the byte is captured in this cycle.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse when the granted byte finishes.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle watchdog abort pulse.
- `tx_wr_en`  out  1  write strobe to `uart_tx.wr_en`.
- `tx_din`  out  DATA_WIDTH  data to `uart_tx.din`.
- `tx_done`  in  1  frame-complete pulse from `uart_tx`.

## Operation
- States:
  - IDLE → ISSUE when any `req` bit is set.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE on `tx_done`, or on timeout when the macro is defined.
- Arbitration runs in IDLE only:
  - Search starts at `last+1` (mod NUM_REQ) and wraps. The first set `req` bit wins.
  - `last` updates to the winner at the grant.
- Grant cycle (IDLE, edge N):
  - `gnt[w]`=1.
  - `tx_din` ← `din_bus[w]`.
  - Winner index is registered as `owner`.
- ISSUE: `tx_wr_en`=1 for exactly one cycle.
- `tx_din` holds its value from ISSUE through WAIT until the next grant.
- WAIT: on `tx_done`, pulse `done[owner]` in the next cycle, together with the return to IDLE.
- `tx_done` in IDLE or ISSUE is ignored.
- Requester contract:
  - A requester keeps `req` high until it sees `gnt`.
  - It drops `req` the cycle after `gnt`, or keeps it high to queue another byte.
  - `req` falling before a grant means no grant, with no side effects.
- Reset values:
  - state=IDLE, `last`=NUM_REQ-1 (so requester 0 wins first).
  - `owner`=0, counter=0.
  - `tx_din`=0, and `gnt`, `done`, `busy`, `err`, `tx_wr_en` all 0.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No `done` is issued for the aborted byte. `uart_tx` shares the same reset.

## Timing
- `req` high in cycle N (IDLE): `gnt` in N, `tx_wr_en` in N+1, `busy` from N+1.
- `tx_done` in cycle M: `done` in M+1 and IDLE in M+1. The earliest next `gnt` is M+1.
- Minimum spacing between successive `tx_wr_en` strobes: 3 cycles plus the frame time.
- Simultaneous requests are served in strict rotation. One requester holding `req` continuously wins every slot when no other requester is active.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without `tx_done`: `err`=1 for one cycle, no `done`, state → IDLE.
  - `tx_done` on the same cycle as the limit counts as completion, with no `err`.
- Macro not defined: no counter. WAIT waits indefinitely and `err` is tied 0.

## Structure
- `uart_pkg`:
  - arbiter state enum (IDLE, ISSUE, WAIT, 2-bit);
  - shared `DATA_WIDTH` default;
  - clog2 helper function.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `req` and `last`; outputs are a one-hot winner and its index. Instantiated once.
- The FSM, `owner`/`last` registers, data register and watchdog live in `uart_tx_arb`.

## Test plan
- Single request: `req[2]`=1 with byte 0xA5 → `gnt[2]` in the same cycle; `tx_wr_en` one cycle later with `tx_din`=0xA5; `done[2]` one cycle after `tx_done`.
- Contention: all four `req` high from reset → grant order 0,1,2,3,0 across five frames; `tx_din` matches each owner's byte.
- Spurious `tx_done` in IDLE and in ISSUE → no state change and no `done`; `tx_din` is stable throughout WAIT.
- Reset asserted during WAIT → next cycle `busy`=0 and `tx_din`=0; no `done`; the first grant after reset goes to requester 0.
- With `UART_TX_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `tx_done` never arrives → `err` pulses 16 cycles after entering WAIT; the arbiter returns to IDLE and the next request is granted.
- Without the macro, `tx_done` withheld for 10k cycles → `busy` stays 1 and `err` stays 0.
